// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle between NUM_IN sources, the round-robin arbiter and its single sink.
// slave is the arbiter's view; master is the view of the sources plus the sink.
interface axis_rr_arbiter_if #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_IN*DATA_WIDTH-1:0] in_tdata;
    logic [NUM_IN-1:0]            in_tvalid;
    logic [NUM_IN-1:0]            in_tlast;
    logic [NUM_IN-1:0]            in_tready;
    logic [DATA_WIDTH-1:0]        out_tdata;
    logic                         out_tvalid;
    logic                         out_tlast;
    logic                         out_tready;

    modport slave (
        input  in_tdata, in_tvalid, in_tlast, out_tready,
        output in_tready, out_tdata, out_tvalid, out_tlast
    );

    modport master (
        output in_tdata, in_tvalid, in_tlast, out_tready,
        input  in_tready, out_tdata, out_tvalid, out_tlast
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI4-Stream sink between NUM_IN sources.
// The datapath is a pure combinational mux steered by the registered one-hot grant.
module axis_rr_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    axis_rr_arbiter_if.slave        bus,
    output logic [NUM_IN-1:0]       grant,
    output logic                    busy
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0]  CNT_CUT   = CNT_W'(MAX_BURST - 1);
    localparam logic [NUM_IN-1:0] ONE_HOT0  = {{(NUM_IN-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [NUM_IN-1:0]       grant_r, grant_nxt_s;
    logic [IDX_W-1:0]        owner_r, owner_nxt_s;
    logic [IDX_W-1:0]        last_grant_r, last_grant_nxt_s;
    logic [CNT_W-1:0]        beat_cnt_r, beat_cnt_nxt_s;
    logic                    busy_r;

    logic [2*NUM_IN-1:0]     rot_s;
    logic                    sel_found_s;
    logic [IDX_W-1:0]        sel_idx_s;
    logic [DATA_WIDTH-1:0]   out_tdata_s;
    logic                    out_tvalid_s;
    logic                    out_tlast_s;
    logic [NUM_IN-1:0]       in_tready_s;
    logic                    beat_s;
    logic                    pkt_end_s;

    // Round-robin pick: rotate requests so last_grant+1 lands at bit 0, take the lowest set bit.
    always_comb begin
        int pos_v;
        int sum_v;
        rot_s = {bus.in_tvalid, bus.in_tvalid} >> ({1'b0, last_grant_r} + {{IDX_W{1'b0}}, 1'b1});
        pos_v = 0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            pos_v = rot_s[i] ? i : pos_v;
        end
        sum_v = int'(last_grant_r) + pos_v + 32'sd1;
        if (sum_v >= NUM_IN) begin
            sum_v = sum_v - NUM_IN;
        end else begin
            sum_v = sum_v;
        end
        sel_found_s = |bus.in_tvalid;
        sel_idx_s   = IDX_W'(sum_v);
    end

    // State register; reset abandons any transfer and hands priority back to input 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            owner_r      <= '0;
            last_grant_r <= LAST_INIT;
            beat_cnt_r   <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            owner_r      <= owner_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            busy_r       <= (state_nxt_s == ST_GRANT);
        end
    end

    // Next-state: grant on any request, release on tlast or on the MAX_BURST-th beat.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        owner_nxt_s      = owner_r;
        last_grant_nxt_s = last_grant_r;
        beat_cnt_nxt_s   = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_nxt_s    = ST_GRANT;
                    grant_nxt_s    = ONE_HOT0 << sel_idx_s;
                    owner_nxt_s    = sel_idx_s;
                    beat_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = '0;
                end
            end
            ST_GRANT: begin
                if (pkt_end_s) begin
                    state_nxt_s      = ST_IDLE;
                    grant_nxt_s      = '0;
                    last_grant_nxt_s = owner_r;
                    beat_cnt_nxt_s   = '0;
                end else if (beat_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                grant_nxt_s    = '0;
                beat_cnt_nxt_s = '0;
            end
        endcase
    end

    // Output mux: AND-OR on the one-hot grant, so everything reads zero while idle.
    always_comb begin
        out_tdata_s  = '0;
        out_tvalid_s = 1'b0;
        out_tlast_s  = 1'b0;
        in_tready_s  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            out_tdata_s    = out_tdata_s | (bus.in_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_r[i]}});
            out_tvalid_s   = out_tvalid_s | (bus.in_tvalid[i] & grant_r[i]);
            out_tlast_s    = out_tlast_s | (bus.in_tlast[i] & grant_r[i]);
            in_tready_s[i] = grant_r[i] & bus.out_tready;
        end
        beat_s    = out_tvalid_s & bus.out_tready;
        pkt_end_s = beat_s & (out_tlast_s | (beat_cnt_r == CNT_CUT));
    end

    assign bus.out_tdata  = out_tdata_s;
    assign bus.out_tvalid = out_tvalid_s;
    assign bus.out_tlast  = out_tlast_s;
    assign bus.in_tready  = in_tready_s;
    assign grant          = grant_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomised bench for axis_rr_arbiter: AXI-compliant source queues, a transaction-level
// round-robin model and a per-beat scoreboard of source id and sequence number.
module tb_axis_rr_arbiter;
    localparam int NUM_IN    = 4;
    localparam int DW        = 16;
    localparam int MAX_BURST = 16;

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic [NUM_IN-1:0] grant;
    logic              busy;

    axis_rr_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW)) bus ();

    axis_rr_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .grant  (grant),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Source side: each queue entry is {tlast, src[3:0], seq[11:0]}.
    logic [16:0]       q [NUM_IN][$];
    logic [11:0]       seq [NUM_IN];
    logic [NUM_IN-1:0] vld  = '0;
    logic [NUM_IN-1:0] mute = '0;
    int                gap_pct    = 0;
    int                ready_mode = 0;
    logic              rdy = 1'b1;

    // Reference model: who owns the sink, who owned it last, beats in the current grant.
    int                m_owner = -1;
    int                m_last  = NUM_IN - 1;
    int                m_beats = 0;
    logic [NUM_IN-1:0] cap_valid, cap_last;
    logic              cap_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_packet(input int src, input int len, input bit with_last);
        for (int b = 0; b < len; b++) begin
            q[src].push_back({(with_last && (b == len - 1)), 4'(src), seq[src]});
            seq[src] = seq[src] + 12'd1;
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NUM_IN; i++) s += q[i].size();
        return s;
    endfunction

    task automatic drive_inputs();
        logic [NUM_IN*DW-1:0] td;
        logic [NUM_IN-1:0]    tl;
        td = '0;
        tl = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!vld[i] && !mute[i] && q[i].size() > 0 && $urandom_range(0, 99) >= gap_pct) vld[i] = 1'b1;
            if (vld[i]) begin
                td[i*DW +: DW] = q[i][0][15:0];
                tl[i]          = q[i][0][16];
            end else begin
                td[i*DW +: DW] = 16'($urandom);
                tl[i]          = 1'($urandom);
            end
        end
        bus.in_tdata  = td;
        bus.in_tvalid = vld;
        bus.in_tlast  = tl;
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        bus.out_tready = rdy;
    endtask

    task automatic check_outputs();
        logic [NUM_IN-1:0] eg, er;
        logic              ev, el;
        logic [DW-1:0]     ed;
        eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
        if (m_owner >= 0) begin
            eg = 4'b0001 << m_owner;
            er = bus.out_tready ? eg : 4'b0000;
            ev = ((bus.in_tvalid & eg) != 4'b0000);
            el = ((bus.in_tlast & eg) != 4'b0000);
            ed = DW'(bus.in_tdata >> (m_owner * DW));
        end
        check_eq("grant",      32'(grant),          32'(eg));
        check_eq("busy",       32'(busy),           32'(m_owner >= 0));
        check_eq("in_tready",  32'(bus.in_tready),  32'(er));
        check_eq("out_tvalid", 32'(bus.out_tvalid), 32'(ev));
        check_eq("out_tlast",  32'(bus.out_tlast),  32'(el));
        check_eq("out_tdata",  32'(bus.out_tdata),  32'(ed));
        if (m_owner >= 0 && ev && bus.out_tready) begin
            check_eq("sb_beat", 32'(bus.out_tdata), 32'(q[m_owner][0][15:0]));
        end
        cap_valid = bus.in_tvalid;
        cap_last  = bus.in_tlast;
        cap_ready = bus.out_tready;
    endtask

    // Applies the arbitration rules to what the sinks/sources presented before the edge.
    task automatic model_update();
        if (m_owner < 0) begin
            for (int k = 1; k <= NUM_IN; k++) begin
                int c;
                c = (m_last + k) % NUM_IN;
                if (m_owner < 0 && ((cap_valid >> c) & 1) != 0) m_owner = c;
            end
            m_beats = 0;
        end else if (((cap_valid >> m_owner) & 1) != 0 && cap_ready) begin
            void'(q[m_owner].pop_front());
            vld = vld & ~(4'b0001 << m_owner);
            m_beats++;
            if (((cap_last >> m_owner) & 1) != 0 || m_beats == MAX_BURST) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic cycle_tail();
        drive_inputs();
        #3;
        check_outputs();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_update();
        cycle_tail();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int budget, input string tag);
        int k = 0;
        while ((pending() != 0 || m_owner >= 0) && k < budget) begin
            cycle();
            k++;
        end
        check_eq(tag, 32'(pending() + ((m_owner >= 0) ? 1 : 0)), 32'd0);
    endtask

    task automatic mid_reset();
        #1 resetn = 1'b0;
        #1;
        check_eq("rst_out_tvalid", 32'(bus.out_tvalid), 32'd0);
        check_eq("rst_grant",      32'(grant),          32'd0);
        check_eq("rst_in_tready",  32'(bus.in_tready),  32'd0);
        check_eq("rst_out_tdata",  32'(bus.out_tdata),  32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        m_owner = -1;
        m_last  = NUM_IN - 1;
        m_beats = 0;
        add_packet(0, 2, 1'b1);
        cycle_tail();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < NUM_IN; i++) seq[i] = 12'd1;
        bus.in_tdata   = '0;
        bus.in_tvalid  = '0;
        bus.in_tlast   = '0;
        bus.out_tready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #4;
        check_eq("reset_grant",      32'(grant),          32'd0);
        check_eq("reset_busy",       32'(busy),           32'd0);
        check_eq("reset_out_tvalid", 32'(bus.out_tvalid), 32'd0);
        check_eq("reset_in_tready",  32'(bus.in_tready),  32'd0);
        check_eq("reset_out_tdata",  32'(bus.out_tdata),  32'd0);
        check_eq("reset_out_tlast",  32'(bus.out_tlast),  32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        cycle_tail();

        // Single 3-beat packet on in0: one-cycle grant latency, then 1,2,3 back to back
        add_packet(0, 3, 1'b1);
        cycle();
        check_eq("t1_latency", 32'(grant), 32'd0);
        for (int b = 1; b <= 3; b++) begin
            cycle();
            check_eq("t1_grant", 32'(grant), 32'd1);
            check_eq("t1_data",  32'(bus.out_tdata), 32'(b));
        end
        cycle();
        check_eq("t1_release", 32'(grant), 32'd0);

        // Every source with 1-beat packets: strict 0,1,2,3 rotation with bubbles
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NUM_IN; i++) add_packet(i, 1, 1'b1);
        drain(100, "t2_drain");

        // 20-beat packet on in2 is cut after MAX_BURST beats; in0 served in between
        add_packet(2, 20, 1'b1);
        cycle();
        add_packet(0, 1, 1'b1);
        drain(100, "t3_drain");

        // Ready toggling during a grant to in1
        ready_mode = 1;
        add_packet(1, 6, 1'b1);
        drain(100, "t4_drain");
        ready_mode = 0;

        // Owner in1 goes quiet mid-packet while in0 waits
        add_packet(1, 4, 1'b1);
        k = 0;
        while (!(m_owner == 1 && m_beats >= 1) && k < 40) begin cycle(); k++; end
        check_eq("t6_setup", 32'(grant), 32'd2);
        mute[1] = 1'b1;
        add_packet(0, 2, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cycle();
            check_eq("t6_hold",   32'(grant),            32'd2);
            check_eq("t6_in0_rdy", 32'(bus.in_tready[0]), 32'd0);
        end
        mute[1] = 1'b0;
        drain(100, "t6_drain");

        // Reset in the middle of an in3 packet, then in0 wins over the leftover in3 beats
        add_packet(3, 20, 1'b1);
        k = 0;
        while (!(m_owner == 3 && m_beats >= 3) && k < 40) begin cycle(); k++; end
        check_eq("t5_setup", 32'(grant), 32'd8);
        mid_reset();
        cycle();
        check_eq("t5_prio", 32'(grant), 32'd1);
        drain(200, "t5_drain");

        // Random traffic: random lengths, gaps, missing tlast and sink back-pressure
        ready_mode = 2;
        gap_pct    = 30;
        for (int n = 0; n < 60; n++) begin
            add_packet($urandom_range(0, NUM_IN - 1), $urandom_range(1, 20), ($urandom_range(0, 9) != 0));
            run($urandom_range(1, 12));
        end
        for (int i = 0; i < NUM_IN; i++) add_packet(i, 1, 1'b1);
        drain(5000, "rand_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
